// File: rtl/axi_lite_error_slave_if.sv
// AXI-Lite channel bundle shared by masters, decoders and terminating responders.
// The slave modport is the responder view; master is its mirror image.
interface axi_lite_channel #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport slave (
        input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
        input  ar_addr, ar_prot, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

    modport master (
        output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
        output ar_addr, ar_prot, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/axi_lite_error_slave.sv
// Default AXI-Lite target: accepts every request and answers with a fixed response.
// Write and read paths are independent single-outstanding FSMs with optional response delay.
module axi_lite_error_slave #(
    parameter logic [1:0]  RESP         = 2'b11,
    parameter logic [63:0] READ_DATA    = 64'h0,
    parameter int unsigned RESP_LATENCY = 0,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic            clk,
    input  logic            rstn,
    axi_lite_channel.slave  master
);

    if (RESP_LATENCY > 255) begin : g_latency_check
        $fatal(1, "axi_lite_error_slave: RESP_LATENCY must be in 0..255");
    end

    localparam logic [7:0] LAT = 8'(RESP_LATENCY);

    typedef enum logic [1:0] {W_ACCEPT, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_ACCEPT, R_WAIT, R_RESP} r_state_t;

    w_state_t   w_state, w_state_n;
    r_state_t   r_state, r_state_n;
    logic       aw_got, aw_got_n;
    logic       w_got, w_got_n;
    logic [7:0] w_cnt, w_cnt_n;
    logic [7:0] r_cnt, r_cnt_n;

    logic aw_rdy, w_rdy, ar_rdy, b_vld, r_vld;
    logic aw_hs, w_hs, ar_hs;

    // Handshake-facing outputs depend only on registered state.
    assign aw_rdy = (w_state == W_ACCEPT) && !aw_got;
    assign w_rdy  = (w_state == W_ACCEPT) && !w_got;
    assign b_vld  = (w_state == W_RESP);
    assign ar_rdy = (r_state == R_ACCEPT);
    assign r_vld  = (r_state == R_RESP);

    assign aw_hs = master.aw_valid && aw_rdy;
    assign w_hs  = master.w_valid  && w_rdy;
    assign ar_hs = master.ar_valid && ar_rdy;

    assign master.aw_ready = aw_rdy;
    assign master.w_ready  = w_rdy;
    assign master.b_valid  = b_vld;
    assign master.b_resp   = RESP;
    assign master.ar_ready = ar_rdy;
    assign master.r_valid  = r_vld;
    assign master.r_resp   = RESP;
    assign master.r_data   = READ_DATA[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= W_ACCEPT;
            r_state <= R_ACCEPT;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            w_cnt   <= '0;
            r_cnt   <= '0;
        end else begin
            w_state <= w_state_n;
            r_state <= r_state_n;
            aw_got  <= aw_got_n;
            w_got   <= w_got_n;
            w_cnt   <= w_cnt_n;
            r_cnt   <= r_cnt_n;
        end
    end

    always_comb begin
        w_state_n = w_state;
        aw_got_n  = aw_got;
        w_got_n   = w_got;
        w_cnt_n   = w_cnt;
        unique case (w_state)
            W_ACCEPT: begin
                if (aw_hs) aw_got_n = 1'b1;
                if (w_hs)  w_got_n  = 1'b1;
                // AW and W may land in either order; respond once both are in.
                if (aw_got_n && w_got_n) begin
                    if (RESP_LATENCY == 0) begin
                        w_state_n = W_RESP;
                    end else begin
                        w_cnt_n   = LAT;
                        w_state_n = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (w_cnt <= 8'd1) begin
                    w_cnt_n   = '0;
                    w_state_n = W_RESP;
                end else begin
                    w_cnt_n = w_cnt - 8'd1;
                end
            end
            W_RESP: begin
                if (master.b_ready) begin
                    aw_got_n  = 1'b0;
                    w_got_n   = 1'b0;
                    w_state_n = W_ACCEPT;
                end
            end
            default: w_state_n = W_ACCEPT;
        endcase
    end

    always_comb begin
        r_state_n = r_state;
        r_cnt_n   = r_cnt;
        unique case (r_state)
            R_ACCEPT: begin
                if (ar_hs) begin
                    if (RESP_LATENCY == 0) begin
                        r_state_n = R_RESP;
                    end else begin
                        r_cnt_n   = LAT;
                        r_state_n = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt <= 8'd1) begin
                    r_cnt_n   = '0;
                    r_state_n = R_RESP;
                end else begin
                    r_cnt_n = r_cnt - 8'd1;
                end
            end
            R_RESP: begin
                if (master.r_ready) r_state_n = R_ACCEPT;
            end
            default: r_state_n = R_ACCEPT;
        endcase
    end

endmodule
